clkctrl_div: RTL

- Parametrised, multi-channel, single-clock-domain clock-control block. Successor to the single-bit sample-on-edge clock controller.
- Each channel divides `clk` by a programmable ratio. It outputs:
  - a one-cycle `tick` enable pulse;
  - a divided `phase` level.
- Each channel starts and stops glitch-free under a level request/acknowledge handshake.
- Sits between the control/sequencer logic and the datapath blocks that need slower strobes or divided phases.

---
 rtl/clkctrl_div.sv | 137 +++++++++++++
 1 files changed

// File: rtl/clkctrl_div.sv
// Multi-channel programmable clock divider: per-channel tick strobe and divided phase, glitch-free start/stop.
// Optional macro CLKCTRL_DIV_SYNC_EN adds a two-flop synchroniser on each en_req bit.
module clkctrl_div #(
  parameter int CH   = 4,
  parameter int DIVW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CH-1:0]      en_req,
  output logic [CH-1:0]      en_ack,
  input  logic [CH*DIVW-1:0] div,
  input  logic [CH-1:0]      load,
  output logic [CH-1:0]      tick,
  output logic [CH-1:0]      phase
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  logic [CH-1:0] en_fsm;

`ifdef CLKCTRL_DIV_SYNC_EN
  logic [CH-1:0] en_meta;
  logic [CH-1:0] en_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_meta <= '0;
      en_sync <= '0;
    end else begin
      en_meta <= en_req;
      en_sync <= en_meta;
    end
  end

  assign en_fsm = en_sync;
`else
  assign en_fsm = en_req;
`endif

  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_t          state;
    logic [DIVW-1:0] cnt;
    logic [DIVW-1:0] shadow;
    logic [DIVW-1:0] div_act;
    logic            ph;
    logic            ack;
    logic            boundary;

    // Boundary depends only on registered state, so tick has no path from any input.
    assign boundary = (state != IDLE) && (cnt == div_act);

    // NOTE: the divisor registers are few and control behaviour, so they get a real
    // reset value rather than being left uninitialised like a datapath memory.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow <= '0;
      end else if (load[i]) begin
        shadow <= div[i*DIVW +: DIVW];
      end
    end

    // NOTE: all state here is updated with non-blocking assignments so every register
    // sees the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state   <= IDLE;
        cnt     <= '0;
        div_act <= '0;
        ph      <= 1'b0;
        ack     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt     <= '0;
            ph      <= 1'b0;
            // Bypass the shadow so a load coinciding with the start governs the first period.
            div_act <= load[i] ? div[i*DIVW +: DIVW] : shadow;
            if (en_fsm[i]) begin
              state <= RUN;
              ack   <= 1'b1;
            end
          end

          RUN: begin
            if (boundary) begin
              cnt     <= '0;
              ph      <= ~ph;
              div_act <= shadow;
            end else begin
              cnt <= cnt + 1'b1;
            end
            if (!en_fsm[i]) begin
              state <= STOP;
            end
          end

          STOP: begin
            if (boundary) begin
              cnt     <= '0;
              div_act <= shadow;
              if (en_fsm[i]) begin
                ph    <= ~ph;
                state <= RUN;
              end else begin
                // Ending a high half-period here closes it at full length; a low one just stays low.
                ph    <= 1'b0;
                ack   <= 1'b0;
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + 1'b1;
              if (en_fsm[i]) begin
                state <= RUN;
              end
            end
          end

          default: begin
            state <= IDLE;
            cnt   <= '0;
            ph    <= 1'b0;
            ack   <= 1'b0;
          end
        endcase
      end
    end

    assign tick[i]   = boundary;
    assign phase[i]  = ph;
    assign en_ack[i] = ack;
  end

endmodule
